// File: rtl/tick_ctrl_pkg.sv
// Shared definitions for the tick_ctrl programmable tick generator.
package tick_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } tick_state_e;

  localparam int unsigned DEF_DIV   = 32'd9;
  localparam int unsigned DEF_BURST = 32'd0;

endpackage

// File: rtl/tick_counter.sv
// Divide counter for tick_ctrl: counts 0..term and strobes wrap on the terminal count.
module tick_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  input  logic [CNT_W-1:0] term,
  output logic             wrap
);

  logic [CNT_W-1:0] cnt_r;

  assign wrap = enable && (cnt_r == term);

  // Count state; clear wins over enable so a stop leaves the counter at zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      cnt_r <= wrap ? '0 : cnt_r + CNT_W'(1);
    end
  end

endmodule

// File: rtl/tick_ctrl.sv
// Programmable tick generator with burst/continuous modes and config handshake.
// Optional square-wave output sq_out is built when TICK_CTRL_SQUARE_EN is defined.
module tick_ctrl
  import tick_ctrl_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               tick,
  output logic               busy,
  output logic               done,
  output logic [BURST_W-1:0] tick_cnt
`ifdef TICK_CTRL_SQUARE_EN
  ,
  output logic               sq_out
`endif
);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_RUN  = RUN;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]         state_r;
  logic [1:0]         state_nxt_s;
  logic [CNT_W-1:0]   div_r;
  logic [BURST_W-1:0] burst_r;
  logic [BURST_W-1:0] tick_cnt_r;
  logic               tick_r;
  logic               done_r;
  logic               busy_r;
  logic               cfg_ready_r;
  logic               idle_s;
  logic               run_s;
  logic               cfg_take_s;
  logic               finish_s;
  logic               cnt_clear_s;
  logic               cnt_en_s;
  logic               wrap_s;

  assign idle_s      = (state_r == ST_IDLE);
  assign run_s       = (state_r == ST_RUN);
  assign cfg_take_s  = cfg_valid && cfg_ready_r;
  // The cycle showing the final burst tick ends the run; no further tick may start.
  assign finish_s    = tick_r && (burst_r != '0) && (tick_cnt_r == burst_r);
  assign cnt_clear_s = !run_s || stop;
  assign cnt_en_s    = run_s && !stop && !finish_s;

  tick_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clk   (clk),
    .reset (reset),
    .clear (cnt_clear_s),
    .enable(cnt_en_s),
    .term  (div_r),
    .wrap  (wrap_s)
  );

  // Next-state decode; stop outranks burst completion.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_RUN;
        else       state_nxt_s = ST_IDLE;
      end
      ST_RUN: begin
        if (stop)          state_nxt_s = ST_IDLE;
        else if (finish_s) state_nxt_s = ST_DONE;
        else               state_nxt_s = ST_RUN;
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM, status flags and latched configuration.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      div_r       <= CNT_W'(DEF_DIV);
      burst_r     <= BURST_W'(DEF_BURST);
      tick_r      <= 1'b0;
      done_r      <= 1'b0;
      busy_r      <= 1'b0;
      cfg_ready_r <= 1'b1;
    end else begin
      state_r     <= state_nxt_s;
      tick_r      <= wrap_s;
      done_r      <= (state_nxt_s == ST_DONE);
      busy_r      <= (state_nxt_s == ST_RUN);
      cfg_ready_r <= (state_nxt_s == ST_IDLE);
      if (cfg_take_s) begin
        div_r   <= cfg_div;
        burst_r <= cfg_burst;
      end
    end
  end

  // Ticks issued in the current run; held across stop, cleared on a new start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick_cnt_r <= '0;
    end else if (idle_s && start) begin
      tick_cnt_r <= '0;
    end else if (wrap_s) begin
      tick_cnt_r <= tick_cnt_r + BURST_W'(1);
    end
  end

`ifdef TICK_CTRL_SQUARE_EN
  logic sq_r;

  // Toggles on each tick so the period is two tick periods.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sq_r <= 1'b0;
    end else if (wrap_s) begin
      sq_r <= !sq_r;
    end
  end

  assign sq_out = sq_r;
`endif

  assign cfg_ready = cfg_ready_r;
  assign tick      = tick_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign tick_cnt  = tick_cnt_r;

endmodule

// File: tb/tb_tick_ctrl.sv
// Self-checking bench for tick_ctrl: cycle-age reference model, directed scenarios, random phase.
module tb_tick_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [15:0] cfg_div = 16'd0;
  logic [7:0]  cfg_burst = 8'd0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        tick;
  logic        busy;
  logic        done;
  logic [7:0]  tick_cnt;
`ifdef TICK_CTRL_SQUARE_EN
  logic        sq_out;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int s;
  int tick_q[$];
  int done_q[$];

  tick_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_div  (cfg_div),
    .cfg_burst(cfg_burst),
    .start    (start),
    .stop     (stop),
    .tick     (tick),
    .busy     (busy),
    .done     (done),
    .tick_cnt (tick_cnt)
`ifdef TICK_CTRL_SQUARE_EN
    ,
    .sq_out   (sq_out)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int q_at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  // Reference model: mode 0 idle / 1 run / 2 done; ticks fall where run age is a multiple of div+1.
  int m_mode, m_age, m_div, m_burst, m_cnt;
  bit m_tick, m_done, m_sq, mp_tick;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = 0; m_age = 0; m_div = 9; m_burst = 0; m_cnt = 0;
      m_tick = 1'b0; m_done = 1'b0; m_sq = 1'b0;
    end else begin
      mp_tick = m_tick;
      m_tick = 1'b0;
      m_done = 1'b0;
      if (m_mode == 0) begin
        if (cfg_valid) begin
          m_div = int'(cfg_div);
          m_burst = int'(cfg_burst);
        end
        if (start) begin
          m_mode = 1; m_age = 0; m_cnt = 0;
        end
      end else if (m_mode == 1) begin
        if (stop) begin
          m_mode = 0;
        end else if (mp_tick && m_burst != 0 && m_cnt == m_burst) begin
          m_mode = 2;
          m_done = 1'b1;
        end else begin
          m_age++;
          if (m_age % (m_div + 1) == 0) begin
            m_tick = 1'b1;
            m_cnt = (m_cnt + 1) % 256;
            m_sq = !m_sq;
          end
        end
      end else begin
        m_mode = 0;
      end
    end
  end

  // Compare DUT against the model on every falling edge out of reset.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      chk("m_tick", tick, m_tick);
      chk("m_done", done, m_done);
      chk("m_busy", busy, (m_mode == 1));
      chk("m_cfg_ready", cfg_ready, (m_mode == 0));
      chk("m_tick_cnt", tick_cnt, m_cnt);
`ifdef TICK_CTRL_SQUARE_EN
      chk("m_sq_out", sq_out, m_sq);
`endif
    end
  end

  task automatic step(input logic st, input logic sp, input logic cv,
                      input logic [15:0] d, input logic [7:0] b);
    start = st; stop = sp; cfg_valid = cv; cfg_div = d; cfg_burst = b;
    @(posedge clk);
    #1;
    if (tick) tick_q.push_back(cyc);
    if (done) done_q.push_back(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 16'd0, 8'd0);
  endtask

  task automatic begin_run(input logic cv, input logic [15:0] d, input logic [7:0] b);
    tick_q.delete();
    done_q.delete();
    step(1'b1, 1'b0, cv, d, b);
    s = cyc;
  endtask

  initial begin
    // Reset state
    #3;
    chk("rst_tick", tick, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_tick_cnt", tick_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);
    chk("idle_cfg_ready", cfg_ready, 1);

    // Continuous, div 9: first tick 10 cycles after start, period 10, 8-bit wrap
    begin_run(1'b1, 16'd9, 8'd0);
    for (int i = 0; i < 3000 && tick_q.size() < 256; i++) idle(1);
    chk("cont_ticks", tick_q.size(), 256);
    chk("cont_wrap_cnt", tick_cnt, 0);
    chk("cont_first", q_at(tick_q, 0) - s, 10);
    chk("cont_period", q_at(tick_q, 5) - q_at(tick_q, 4), 10);
    chk("cont_no_done", done_q.size(), 0);
    step(1'b0, 1'b1, 1'b0, 16'd0, 8'd0);
    idle(2);

    // Burst of 4 at div 3
    begin_run(1'b1, 16'd3, 8'd4);
    idle(25);
    chk("b4_ticks", tick_q.size(), 4);
    chk("b4_first", q_at(tick_q, 0) - s, 4);
    chk("b4_period", q_at(tick_q, 3) - q_at(tick_q, 2), 4);
    chk("b4_dones", done_q.size(), 1);
    chk("b4_done_lag", q_at(done_q, 0) - q_at(tick_q, 3), 1);
    chk("b4_busy_after", busy, 0);
    chk("b4_cnt_held", tick_cnt, 4);

    // div 0, burst 2: back-to-back ticks then done
    begin_run(1'b1, 16'd0, 8'd2);
    idle(8);
    chk("d0_ticks", tick_q.size(), 2);
    chk("d0_t0", q_at(tick_q, 0) - s, 1);
    chk("d0_t1", q_at(tick_q, 1) - s, 2);
    chk("d0_done", q_at(done_q, 0) - s, 3);

    // Stop on the terminal-count cycle: no tick, no done, back to idle
    begin_run(1'b1, 16'd9, 8'd0);
    idle(19);
    step(1'b0, 1'b1, 1'b0, 16'd0, 8'd0);
    chk("stop_tick", tick, 0);
    chk("stop_done", done, 0);
    chk("stop_busy", busy, 0);
    chk("stop_cfg_ready", cfg_ready, 1);
    chk("stop_cnt_held", tick_cnt, 1);
    chk("stop_ticks", tick_q.size(), 1);
    idle(3);

    // Config offered during a run is ignored
    begin_run(1'b1, 16'd9, 8'd0);
    idle(5);
    step(1'b0, 1'b0, 1'b1, 16'd1, 8'd0);
    for (int i = 0; i < 60 && tick_q.size() < 3; i++) idle(1);
    chk("cfgrun_first", q_at(tick_q, 0) - s, 10);
    chk("cfgrun_period", q_at(tick_q, 2) - q_at(tick_q, 1), 10);
    step(1'b0, 1'b1, 1'b0, 16'd0, 8'd0);
    idle(1);
    // Config and start together use the new divider
    begin_run(1'b1, 16'd1, 8'd0);
    idle(6);
    chk("cfgstart_first", q_at(tick_q, 0) - s, 2);
    chk("cfgstart_period", q_at(tick_q, 1) - q_at(tick_q, 0), 2);
    step(1'b0, 1'b1, 1'b0, 16'd0, 8'd0);
    idle(1);

    // Asynchronous reset mid-burst, then a run on the default divider
    begin_run(1'b1, 16'd3, 8'd5);
    idle(4);
    chk("mid_tick_before", tick, 1);
    tick_q.delete();
    done_q.delete();
    #1 reset = 1'b0;
    #1;
    chk("arst_tick", tick, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_tick_cnt", tick_cnt, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    idle(2);
    chk("arst_no_done", done_q.size(), 0);
    begin_run(1'b0, 16'd0, 8'd0);
    idle(12);
    chk("arst_def_div", q_at(tick_q, 0) - s, 10);
    step(1'b0, 1'b1, 1'b0, 16'd0, 8'd0);
    idle(1);

    // Random traffic against the model
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 5) == 0), ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 7) == 0), 16'($urandom_range(0, 5)),
           8'($urandom_range(0, 6)));
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/tick_ctrl.md
TICK_CTRL -- requirements
Module: tick_ctrl

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the divide-counter and cfg_div width.
REQ-002 Parameter BURST_W, default 8, SHALL set the cfg_burst and tick_cnt width.
REQ-003 clk  in  1  SHALL be the single clock; all logic on rising edge.
REQ-004 reset  in  1  SHALL be asynchronous and active-low.
REQ-005 cfg_valid  in  1  SHALL mark configuration offered.
REQ-006 cfg_ready  out  1  SHALL mark configuration accepted this cycle.
REQ-007 cfg_div  in  CNT_W  SHALL give the terminal count; tick period = cfg_div+1 cycles.
REQ-008 cfg_burst  in  BURST_W  SHALL give the tick count per run; 0 = continuous.
REQ-009 start  in  1  SHALL request a run, level-sampled.
REQ-010 stop  in  1  SHALL abort a run, level-sampled.
REQ-011 tick  out  1  SHALL be a registered one-cycle pulse per period.
REQ-012 busy  out  1  SHALL be high in RUN.
REQ-013 done  out  1  SHALL be a one-cycle pulse on burst completion.
REQ-014 tick_cnt  out  BURST_W  SHALL count ticks issued in the current run.

Function
REQ-015 FSM states SHALL be IDLE, RUN and DONE.
REQ-016 cfg_ready SHALL equal (state==IDLE); the handshake completes when cfg_valid&&cfg_ready, latching div_reg and burst_reg.
REQ-017 cfg_valid outside IDLE SHALL be ignored; the latched config is unchanged.
REQ-018 In IDLE, start SHALL move to RUN next cycle, clearing counter and tick_cnt.
REQ-019 Config handshake and start in the same IDLE cycle SHALL run with the newly latched config.
REQ-020 In RUN, counter SHALL increment each cycle, wrapping to 0 after reaching div_reg.
REQ-021 tick SHALL be high in the cycle after counter==div_reg; first tick = div_reg+1 cycles after the start edge.
REQ-022 div_reg==0 SHALL give tick every cycle in RUN.
REQ-023 tick_cnt SHALL increment with each tick and wrap modulo 2^BURST_W in continuous mode.
REQ-024 With burst_reg!=0, the tick that makes tick_cnt==burst_reg SHALL move to DONE; done pulses in the DONE cycle, then the FSM enters IDLE.
REQ-025 start in RUN or DONE SHALL be ignored.
REQ-026 stop in RUN SHALL move to IDLE next cycle, with no done, counter cleared and tick_cnt held. Stop SHALL take priority over a same-cycle terminal count, so no tick is issued.
REQ-027 stop in IDLE or DONE SHALL have no effect.

Reset
REQ-028 Reset low SHALL immediately force the following: state=IDLE, counter=0, tick=0, done=0, busy=0, tick_cnt=0, div_reg=9, burst_reg=0.
REQ-029 Reset asserted mid-run SHALL abort with no done pulse; after release, the block waits for start.

Configuration
REQ-030 With TICK_CTRL_SQUARE_EN defined, output sq_out (1 bit, reset 0) SHALL toggle on every tick, giving 50% duty at period 2*(div_reg+1). It SHALL hold its value in IDLE.
REQ-031 Without TICK_CTRL_SQUARE_EN, sq_out and its register SHALL be absent.

Structure
REQ-032 Package tick_ctrl_pkg SHALL hold the state enum and DEF_DIV=9 and DEF_BURST=0.
REQ-033 The divide counter SHALL be sub-module tick_counter, with clear, enable and terminal-count inputs and a wrap-strobe output.

Verification
REQ-034 cfg_div=9, cfg_burst=0, start: ticks every 10 cycles, first at cycle 10; tick_cnt wraps 255->0.
REQ-035 cfg_div=3, cfg_burst=4, start: 4 ticks 4 cycles apart; done one cycle after the 4th tick; busy low after done.
REQ-036 cfg_div=0, cfg_burst=2: tick on 2 consecutive cycles, then done.
REQ-037 stop on the cycle counter==div_reg: no tick, no done; IDLE next cycle; cfg_ready=1.
REQ-038 cfg_valid during RUN with cfg_div=1: ignored and period unchanged; cfg_valid and start in the same IDLE cycle: the new divider is used.
REQ-039 Reset low mid-burst: all outputs 0 asynchronously; a run after release uses div=9.
